// File: rtl/tb_sim_ctrl.sv
// Test bench controller: sequenced core reset, divided clock enables, multi-channel
// error aggregation, timeout watchdog and an end-of-run state machine with drain.
module tb_sim_ctrl #(
    parameter int NUM_CHAN      = 4,
    parameter int RST_CYCLES    = 10,
    parameter int DRAIN_CYCLES  = 8,
    parameter int NUM_DIV       = 2,
    parameter int STOP_ON_ERROR = 1,
    parameter int GUI_RUN       = 0,
    parameter int SIM_REPORT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                core_rst_n,
    output logic [NUM_DIV-1:0]  clk_en_div,
    output logic [31:0]         count_vec,
    input  logic [31:0]         timeout,
    input  logic [NUM_CHAN-1:0] error,
    input  logic                do_stop,
    input  logic                do_finish,
    input  logic                partial_test,
    output logic [NUM_CHAN-1:0] err_mask,
    output logic [4:0]          first_err_chan,
    output logic [2:0]          end_cause,
    output logic [1:0]          state,
    output logic                passed,
    output logic                failed
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_FINISH  = 3'd1;
    localparam logic [2:0] CAUSE_STOP    = 3'd2;
    localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
    localparam logic [2:0] CAUSE_ERROR   = 3'd4;

    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    function automatic logic [4:0] lowest_idx(input logic [NUM_CHAN-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = 5'(i);
        end
    endfunction

    state_t               state_q, state_d;
    logic                 core_q, core_d;
    logic [31:0]          count_q;
    logic [NUM_DIV-1:0]   div_q, div_inc, en_q, en_d;
    logic [NUM_CHAN-1:0]  err_q, err_d, err_new;
    logic [4:0]           first_q, first_d;
    logic [2:0]           cause_q, cause_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 passed_q, passed_d;
    logic                 failed_q, failed_d;
    logic                 tmo_hit;
    logic                 end_hit;
    logic [2:0]           end_code;

    assign tmo_hit = (timeout != 32'd0) && (count_q == timeout);
    assign div_inc = div_q + NUM_DIV'(1);

    // Enable k fires when the low k+1 bits of the next divider value are all ones,
    // giving the first pulse 2^(k+1) cycles after release.
    for (genvar k = 0; k < NUM_DIV; k++) begin : g_div
        assign en_d[k] = &div_inc[k:0];
    end

    always_comb begin
        state_d  = state_q;
        core_d   = core_q;
        cause_d  = cause_q;
        drain_d  = drain_q;
        first_d  = first_q;
        passed_d = passed_q;
        failed_d = failed_q;
        end_hit  = 1'b0;
        end_code = CAUSE_NONE;

        err_new = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) ? error : '0;
        err_d   = err_q | err_new;
        if ((err_q == '0) && (err_new != '0)) begin
            first_d = lowest_idx(err_new);
        end

        // Errors only end the run once the core is out of reset.
        if (tmo_hit) begin
            end_hit  = 1'b1;
            end_code = CAUSE_TIMEOUT;
        end else if ((STOP_ON_ERROR != 0) && (state_q == ST_RUN) && (|error)) begin
            end_hit  = 1'b1;
            end_code = CAUSE_ERROR;
        end else if (do_stop) begin
            end_hit  = 1'b1;
            end_code = CAUSE_STOP;
        end else if (do_finish) begin
            end_hit  = 1'b1;
            end_code = CAUSE_FINISH;
        end

        case (state_q)
            ST_RST, ST_RUN: begin
                if (end_hit) begin
                    state_d = ST_DRAIN;
                    cause_d = end_code;
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                end else if ((state_q == ST_RST) && (count_q == 32'(RST_CYCLES - 1))) begin
                    state_d = ST_RUN;
                    core_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d  = ST_DONE;
                    failed_d = (err_d != '0) || (cause_q == CAUSE_TIMEOUT);
                    passed_d = !((err_d != '0) || (cause_q == CAUSE_TIMEOUT));
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            core_q   <= 1'b0;
            count_q  <= '0;
            div_q    <= '0;
            en_q     <= '0;
            err_q    <= '0;
            first_q  <= '0;
            cause_q  <= CAUSE_NONE;
            drain_q  <= '0;
            passed_q <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            core_q   <= core_d;
            count_q  <= (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
            div_q    <= div_inc;
            en_q     <= en_d;
            err_q    <= err_d;
            first_q  <= first_d;
            cause_q  <= cause_d;
            drain_q  <= drain_d;
            passed_q <= passed_d;
            failed_q <= failed_d;
        end
    end

    assign core_rst_n     = core_q;
    assign clk_en_div     = en_q;
    assign count_vec      = count_q;
    assign err_mask       = err_q;
    assign first_err_chan = first_q;
    assign end_cause      = cause_q;
    assign state          = state_q;
    assign passed         = passed_q;
    assign failed         = failed_q;

`ifndef SYNTHESIS
    // One-shot end-of-run report; DONE is terminal so this fires once per reset.
    logic report_done;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            report_done <= 1'b0;
        end else if ((state_q == ST_DONE) && !report_done) begin
            report_done <= 1'b1;
            if (SIM_REPORT != 0) begin
                if (err_q != '0)                    $display("*** FAIL: errors found");
                else if (cause_q == CAUSE_TIMEOUT)  $display("*** FAIL: timeout");
                else if (partial_test)              $display("NO FAILURES");
                else                                $display("SUCCESS");
                if ((GUI_RUN != 0) || (cause_q == CAUSE_STOP)) $stop;
                else                                           $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Directed bench for tb_sim_ctrl: a default instance and a no-stop-on-error,
// zero-drain instance share one stimulus set.
module tb_tb_sim_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] timeout = '0;
    logic [3:0]  error = '0;
    logic        do_stop = 1'b0;
    logic        do_finish = 1'b0;
    logic        partial_test = 1'b0;

    logic        core_a, core_b;
    logic [1:0]  div_a, div_b;
    logic [31:0] count_a, count_b;
    logic [3:0]  mask_a, mask_b;
    logic [4:0]  first_a, first_b;
    logic [2:0]  cause_a, cause_b;
    logic [1:0]  state_a, state_b;
    logic        passed_a, passed_b, failed_a, failed_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tb_sim_ctrl #(.NUM_CHAN(4), .RST_CYCLES(10), .DRAIN_CYCLES(8), .NUM_DIV(2),
                  .STOP_ON_ERROR(1), .GUI_RUN(0), .SIM_REPORT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .core_rst_n(core_a), .clk_en_div(div_a),
        .count_vec(count_a), .timeout(timeout), .error(error), .do_stop(do_stop),
        .do_finish(do_finish), .partial_test(partial_test), .err_mask(mask_a),
        .first_err_chan(first_a), .end_cause(cause_a), .state(state_a),
        .passed(passed_a), .failed(failed_a));

    tb_sim_ctrl #(.NUM_CHAN(4), .RST_CYCLES(10), .DRAIN_CYCLES(0), .NUM_DIV(2),
                  .STOP_ON_ERROR(0), .GUI_RUN(0), .SIM_REPORT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .core_rst_n(core_b), .clk_en_div(div_b),
        .count_vec(count_b), .timeout(timeout), .error(error), .do_stop(do_stop),
        .do_finish(do_finish), .partial_test(partial_test), .err_mask(mask_b),
        .first_err_chan(first_b), .end_cause(cause_b), .state(state_b),
        .passed(passed_b), .failed(failed_b));

    typedef struct {
        logic        rst_n;
        logic [31:0] cnt;
        logic        core;
        logic [1:0]  div;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int unsigned n);
        int guard;
        guard = 0;
        while ((count_a < n) && (guard < 20000)) begin
            step();
            guard++;
        end
        check("run_to", count_a, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; do_stop = 1'b0; do_finish = 1'b0;
        error = '0; timeout = '0; partial_test = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'd0,  1'b0, 2'b00, 2'd0};
        tbl[1]  = '{1'b1, 32'd1,  1'b0, 2'b01, 2'd0};
        tbl[2]  = '{1'b1, 32'd2,  1'b0, 2'b00, 2'd0};
        tbl[3]  = '{1'b1, 32'd3,  1'b0, 2'b11, 2'd0};
        tbl[4]  = '{1'b1, 32'd4,  1'b0, 2'b00, 2'd0};
        tbl[5]  = '{1'b1, 32'd5,  1'b0, 2'b01, 2'd0};
        tbl[6]  = '{1'b1, 32'd6,  1'b0, 2'b00, 2'd0};
        tbl[7]  = '{1'b1, 32'd7,  1'b0, 2'b11, 2'd0};
        tbl[8]  = '{1'b1, 32'd8,  1'b0, 2'b00, 2'd0};
        tbl[9]  = '{1'b1, 32'd9,  1'b0, 2'b01, 2'd0};
        tbl[10] = '{1'b1, 32'd10, 1'b1, 2'b00, 2'd1};
        tbl[11] = '{1'b1, 32'd11, 1'b1, 2'b11, 2'd1};
        tbl[12] = '{1'b1, 32'd12, 1'b1, 2'b00, 2'd1};
        tbl[13] = '{1'b0, 32'd0,  1'b0, 2'b00, 2'd0};
        tbl[14] = '{1'b1, 32'd1,  1'b0, 2'b01, 2'd0};

        // Reset release, core reset sequencing and divider pattern
        for (int i = 0; i < 15; i++) begin
            rst_n = tbl[i].rst_n;
            step();
            check($sformatf("tbl%0d count", i), count_a, tbl[i].cnt);
            check($sformatf("tbl%0d core_rst_n", i), core_a, tbl[i].core);
            check($sformatf("tbl%0d clk_en_div", i), div_a, tbl[i].div);
            check($sformatf("tbl%0d state", i), state_a, tbl[i].st);
            if (i == 0) begin
                check("rst err_mask", mask_a, 0);
                check("rst first_err_chan", first_a, 0);
                check("rst end_cause", cause_a, 0);
                check("rst passed", passed_a, 0);
                check("rst failed", failed_a, 0);
            end
        end

        // Finish at count 50; second pass with partial_test set
        for (int pt = 0; pt < 2; pt++) begin
            do_reset();
            partial_test = pt[0];
            run_to(50);
            do_finish = 1'b1;
            step();
            do_finish = 1'b0;
            check("fin drain state", state_a, 2);
            check("fin cause", cause_a, 1);
            check("fin b drain state", state_b, 2);
            step();
            check("fin b done zero-drain", state_b, 3);
            check("fin b passed", passed_b, 1);
            run_to(59);
            check("fin still drain@59", state_a, 2);
            check("fin passed before done", passed_a, 0);
            step();
            check("fin done@60", state_a, 3);
            check("fin passed", passed_a, 1);
            check("fin failed", failed_a, 0);
            check("fin core_rst_n", core_a, 1);
        end

        // Two channels erroring together
        do_reset();
        run_to(30);
        error = 4'b0110;
        step();
        error = '0;
        check("err state", state_a, 2);
        check("err cause", cause_a, 4);
        check("err mask", mask_a, 4'b0110);
        check("err first chan", first_a, 1);
        run_to(40);
        check("err done", state_a, 3);
        check("err failed", failed_a, 1);
        check("err passed", passed_a, 0);

        // Watchdog at 100
        do_reset();
        timeout = 32'd100;
        run_to(100);
        check("tmo run@100", state_a, 1);
        step();
        check("tmo drain", state_a, 2);
        check("tmo cause", cause_a, 3);
        run_to(110);
        check("tmo done", state_a, 3);
        check("tmo failed", failed_a, 1);
        check("tmo mask", mask_a, 0);

        // Timeout coincident with an error
        do_reset();
        timeout = 32'd25;
        run_to(25);
        error = 4'b0001;
        step();
        error = '0;
        check("tmo+err cause", cause_a, 3);
        check("tmo+err mask", mask_a, 4'b0001);
        check("tmo+err first", first_a, 0);

        // Stop request while still in core reset
        do_reset();
        run_to(5);
        do_stop = 1'b1;
        step();
        do_stop = 1'b0;
        check("rststop state", state_a, 2);
        check("rststop cause", cause_a, 2);
        run_to(15);
        check("rststop done", state_a, 3);
        check("rststop core_rst_n", core_a, 0);
        check("rststop passed", passed_a, 1);

        // No stop on error, stop+finish together, error during drain
        do_reset();
        run_to(40);
        error = 4'b1000;
        step();
        error = '0;
        check("b run after err", state_b, 1);
        check("b mask1", mask_b, 4'b1000);
        check("b first", first_b, 3);
        run_to(80);
        do_stop = 1'b1;
        do_finish = 1'b1;
        step();
        do_stop = 1'b0;
        do_finish = 1'b0;
        check("b drain", state_b, 2);
        check("b cause stop", cause_b, 2);
        error = 4'b0001;
        step();
        error = '0;
        check("b done", state_b, 3);
        check("b mask2", mask_b, 4'b1001);
        check("b first kept", first_b, 3);
        check("b failed", failed_b, 1);
        check("b passed", passed_b, 0);

        // Reset dropped during drain, then a clean run
        do_reset();
        run_to(20);
        do_finish = 1'b1;
        step();
        do_finish = 1'b0;
        run_to(24);
        check("abort in drain", state_a, 2);
        rst_n = 1'b0;
        step();
        check("abort count", count_a, 0);
        check("abort state", state_a, 0);
        check("abort core", core_a, 0);
        check("abort cause", cause_a, 0);
        check("abort div", div_a, 0);
        check("abort passed", passed_a, 0);
        check("abort failed", failed_a, 0);
        rst_n = 1'b1;
        run_to(30);
        do_finish = 1'b1;
        step();
        do_finish = 1'b0;
        run_to(40);
        check("rerun done", state_a, 3);
        check("rerun passed", passed_a, 1);
        check("rerun cause", cause_a, 1);

        // Watchdog disabled: long idle run
        do_reset();
        run_to(10000);
        check("idle state", state_a, 1);
        check("idle cause", cause_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tb_sim_ctrl.md
Name: tb_sim_ctrl

Overview:
Parametrised successor to the single-channel test bench controller. Runs from an externally supplied clock and reset, and does the following:
- sequences a programmable core reset;
- produces divided clock enables;
- aggregates errors from multiple checker channels;
- runs a timeout watchdog;
- steps through an end-of-simulation state machine with a drain period.

It sits at the top of each directed test bench, between the checkers/VProc stop requests and the DUT reset/enable pins.

Parameters:
NUM_CHAN, 4, number of independent error-input channels (1..32)
RST_CYCLES, 10, cycles core_rst_n is held low after rst_n releases (>=1)
DRAIN_CYCLES, 8, cycles spent in DRAIN before DONE (0 = go straight to DONE)
NUM_DIV, 2, number of divided clock enables (1..8)
STOP_ON_ERROR, 1, 1 = first error ends the run; 0 = errors only recorded
GUI_RUN, 0, non-zero = DONE always issues $stop

Ports:
clk  input  1  bench clock
rst_n  input  1  synchronous active-low reset
core_rst_n  output  1  sequenced DUT reset, active-low
clk_en_div  output  NUM_DIV  bit k pulses once every 2^(k+1) cycles
count_vec  output  32  cycle count since rst_n release
timeout  input  32  absolute cycle limit; 0 disables the watchdog
error  input  NUM_CHAN  per-channel error level
do_stop  input  1  stop request
do_finish  input  1  finish request
partial_test  input  1  pass is reported as partial
err_mask  output  NUM_CHAN  sticky per-channel error flags
first_err_chan  output  5  index of the first channel to error
end_cause  output  3  0 none, 1 finish, 2 stop, 3 timeout, 4 error
state  output  2  0 RST, 1 RUN, 2 DRAIN, 3 DONE
passed  output  1  run ended with no failure
failed  output  1  run ended with a failure

Behaviour:
- Reset (rst_n=0 at a clk edge) sets all registers at that edge:
  - core_rst_n=0, count_vec=0, clk_en_div=0, err_mask=0, first_err_chan=0, end_cause=0, state=RST, passed=0, failed=0.
- Reset mid-run aborts immediately with the same values. No simulation action is issued.
- count_vec:
  - increments by 1 on every edge with rst_n=1;
  - saturates at 32'hFFFFFFFF, no wrap.
- clk_en_div:
  - free-running divider counter, NUM_DIV bits, reset 0, increments every cycle and wraps;
  - bit k is registered high for one cycle when divider bits [k:0] are all ones;
  - first pulse of bit k is on cycle 2^(k+1) after release (div2 on cycles 2,4,6…; div4 on cycles 4,8…).
- RST state:
  - core_rst_n=0; errors ignored.
  - At the edge where count_vec==RST_CYCLES-1, go to RUN and set core_rst_n=1.
  - core_rst_n is first high in cycle RST_CYCLES+1 counting from release.
  - do_stop/do_finish/timeout are honoured in RST and go directly to DRAIN; core_rst_n stays 0.
- RUN state: end conditions are evaluated each cycle, with priority
  - timeout!=0 and count_vec==timeout → cause 3
  - STOP_ON_ERROR and |error → cause 4
  - do_stop → 2
  - do_finish → 1
  - On any end condition: latch end_cause and go to DRAIN at the same edge.
- Error recording:
  - err_mask[i] sets when error[i]=1 in RUN or DRAIN, and stays set until reset.
  - first_err_chan is captured on the first set; if several channels rise together, the lowest index wins.
- DRAIN state:
  - down-counter loads DRAIN_CYCLES on entry; go to DONE when it reaches 0;
  - with DRAIN_CYCLES=0, DONE follows DRAIN after one cycle;
  - errors keep accumulating; end_cause is frozen;
  - core_rst_n keeps its value.
- DONE state (terminal):
  - failed = (err_mask!=0) or end_cause==3; passed = !failed. Both registered, asserted on DONE entry, held until reset.
  - Exactly one message is printed on entry, in this priority:
    - "*** FAIL: errors found" if err_mask!=0;
    - else "*** FAIL: timeout" if end_cause==3;
    - else "NO FAILURES" if partial_test=1;
    - else "SUCCESS".
  - Then $stop if GUI_RUN!=0 or end_cause==2; otherwise $finish.
  - The message and simulation action are guarded by a one-shot flag and sit in non-synthesised code.
- Simultaneous events:
  - do_stop and do_finish together → cause 2 ($stop).
  - timeout coincident with an error → cause 3, and err_mask still records the error.

Test Plan:
- Release rst_n at cycle 0, RST_CYCLES=10, no requests → core_rst_n rises with count_vec==10; clk_en_div[0] pulses at counts 1,3,5; clk_en_div[1] at counts 3,7.
- do_finish pulsed at count 50, DRAIN_CYCLES=8 → DRAIN at 51, DONE at 60; end_cause=1, passed=1, "SUCCESS"; repeat with partial_test=1 → "NO FAILURES".
- error[2] and error[1] both rise at count 30, STOP_ON_ERROR=1 → end_cause=4, err_mask=4'b0110, first_err_chan=1, failed=1, "errors found".
- timeout=100, no requests → end_cause=3, failed=1 at DONE; timeout=0 with 10000 idle cycles → state stays RUN.
- STOP_ON_ERROR=0, error[3] at 40, do_stop at 80, error[0] during DRAIN → err_mask=4'b1001, end_cause=2, failed=1, $stop issued.
- rst_n dropped in DRAIN → all outputs return to reset values next edge, no message; normal run completes after re-release.
